mem_access_unit: RTL and testbench

Parametrised load/store unit that sits in the memory stage of the pipelined core. It replaces the fixed single-cycle memory path with a req/ack handshake to a variable-latency memory. It stalls the pipeline while an access is outstanding and generalises data width to XLEN 32 or 64, including LD/SD/LWU. It also reports misaligned, illegal and timed-out accesses as faults instead of issuing them.

---
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Issue-side and memory-side signal bundle for the load/store unit.
// "master" is the unit itself (it masters the memory bus); "slave" is the
// surrounding pipeline/memory that drives issue and completion signals.
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic              issue_valid;
    logic              issue_load;
    logic              issue_store;
    logic [2:0]        func3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   store_data;
    logic [4:0]        rd_addr;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;
    logic              load_valid;
    logic [XLEN-1:0]   load_data;
    logic [4:0]        load_rd;
    logic              fault;
    logic [1:0]        fault_cause;

    modport master (
        input  issue_valid, issue_load, issue_store, func3, addr, store_data, rd_addr,
        input  mem_rdata, mem_ack,
        output stall, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        output load_valid, load_data, load_rd, fault, fault_cause
    );

    modport slave (
        output issue_valid, issue_load, issue_store, func3, addr, store_data, rd_addr,
        output mem_rdata, mem_ack,
        input  stall, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  load_valid, load_data, load_rd, fault, fault_cause
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes an access, faults illegal or
// misaligned ones, otherwise issues a held req/ack transaction to a
// variable-latency memory and returns extended load data one cycle after ack.
module mem_access_unit #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    mem_access_unit_if.master     bus
);
    localparam int STRB   = XLEN / 8;
    localparam int LANE_W = $clog2(STRB);
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit IS64   = (XLEN == 64);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
    logic [STRB-1:0]    mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [LANE_W-1:0]  ld_lane_q, ld_lane_d;
    logic [4:0]         ld_rd_q, ld_rd_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               load_valid_q, load_valid_d;
    logic [XLEN-1:0]    load_data_q, load_data_d;
    logic [4:0]         load_rd_q, load_rd_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_cause_q, fault_cause_d;

    logic               ld_ok_s, st_ok_s, illegal_s, misal_s;
    logic               is_mem_s, accept_s, reject_s, tmo_hit_s;
    logic [LANE_W-1:0]  lane_s;
    logic [7:0]         size_mask_s;

    // Shift the addressed lane down and sign/zero-extend by funct3.
    function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] rdata,
                                                     input logic [LANE_W-1:0] lane,
                                                     input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  extract_load = XLEN'($signed(sh[7:0]));
            3'b001:  extract_load = XLEN'($signed(sh[15:0]));
            3'b010:  extract_load = XLEN'($signed(sh[31:0]));
            3'b100:  extract_load = XLEN'(sh[7:0]);
            3'b101:  extract_load = XLEN'(sh[15:0]);
            3'b110:  extract_load = XLEN'(sh[31:0]);
            default: extract_load = sh;
        endcase
    endfunction

    // Decode legality, alignment and the accept/reject decision in IDLE.
    always_comb begin
        lane_s = bus.addr[LANE_W-1:0];
        case (bus.func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_ok_s = 1'b1;
            3'b011, 3'b110:                         ld_ok_s = IS64;
            default:                                ld_ok_s = 1'b0;
        endcase
        case (bus.func3)
            3'b000, 3'b001, 3'b010: st_ok_s = 1'b1;
            3'b011:                 st_ok_s = IS64;
            default:                st_ok_s = 1'b0;
        endcase
        if (bus.issue_load && bus.issue_store) begin
            illegal_s = 1'b1;
        end else if (bus.issue_load) begin
            illegal_s = !ld_ok_s;
        end else if (bus.issue_store) begin
            illegal_s = !st_ok_s;
        end else begin
            illegal_s = 1'b0;
        end
        case (bus.func3[1:0])
            2'b01:   misal_s = bus.addr[0];
            2'b10:   misal_s = (bus.addr[1:0] != 2'b00);
            2'b11:   misal_s = (bus.addr[2:0] != 3'b000);
            default: misal_s = 1'b0;
        endcase
        case (bus.func3[1:0])
            2'b00:   size_mask_s = 8'h01;
            2'b01:   size_mask_s = 8'h03;
            2'b10:   size_mask_s = 8'h0F;
            default: size_mask_s = 8'hFF;
        endcase
        is_mem_s  = bus.issue_valid && (bus.issue_load || bus.issue_store);
        accept_s  = (state_q == ST_IDLE) && is_mem_s && !illegal_s && !misal_s;
        reject_s  = (state_q == ST_IDLE) && is_mem_s && (illegal_s || misal_s);
        tmo_hit_s = (TIMEOUT_CYC > 0) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Stall the pipeline on accept and for every WAIT cycle; never during reset.
    always_comb begin
        bus.stall = 1'b0;
        if (rst) begin
            bus.stall = 1'b0;
        end else begin
            bus.stall = accept_s || (state_q == ST_WAIT);
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT controller.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wmask_d   = mem_wmask_q;
        mem_wdata_d   = mem_wdata_q;
        ld_f3_d       = ld_f3_q;
        ld_lane_d     = ld_lane_q;
        ld_rd_d       = ld_rd_q;
        tmo_cnt_d     = tmo_cnt_q;
        load_valid_d  = 1'b0;
        load_data_d   = load_data_q;
        load_rd_d     = load_rd_q;
        fault_d       = 1'b0;
        fault_cause_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d     = ST_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.issue_store;
                    mem_addr_d  = {bus.addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                    mem_wdata_d = bus.store_data << {lane_s, 3'b000};
                    mem_wmask_d = bus.issue_store ? (STRB'(size_mask_s) << lane_s) : {STRB{1'b0}};
                    ld_f3_d     = bus.func3;
                    ld_lane_d   = lane_s;
                    ld_rd_d     = bus.rd_addr;
                    tmo_cnt_d   = {TMO_W{1'b0}};
                end else if (reject_s) begin
                    fault_d       = 1'b1;
                    fault_cause_d = illegal_s ? 2'b10 : 2'b01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An ack landing on the timeout cycle still completes the access.
                if (bus.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = extract_load(bus.mem_rdata, ld_lane_q, ld_f3_q);
                        load_rd_d    = ld_rd_q;
                    end else begin
                        load_valid_d = 1'b0;
                    end
                end else if (tmo_hit_s) begin
                    state_d       = ST_IDLE;
                    mem_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b11;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wmask_q   <= '0;
            mem_wdata_q   <= '0;
            ld_f3_q       <= 3'b000;
            ld_lane_q     <= '0;
            ld_rd_q       <= 5'd0;
            tmo_cnt_q     <= '0;
            load_valid_q  <= 1'b0;
            load_data_q   <= '0;
            load_rd_q     <= 5'd0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_wdata_q   <= mem_wdata_d;
            ld_f3_q       <= ld_f3_d;
            ld_lane_q     <= ld_lane_d;
            ld_rd_q       <= ld_rd_d;
            tmo_cnt_q     <= tmo_cnt_d;
            load_valid_q  <= load_valid_d;
            load_data_q   <= load_data_d;
            load_rd_q     <= load_rd_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wmask   = mem_wmask_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.load_valid  = load_valid_q;
    assign bus.load_data   = load_data_q;
    assign bus.load_rd     = load_rd_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = fault_cause_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one XLEN=32 and one XLEN=64 instance (both with
// a 4-cycle timeout), directed scenarios followed by randomized transactions
// compared against a byte-arithmetic reference model.
module tb_mem_access_unit;
    localparam int TMO = 4;

    logic        CLK;
    logic        rst;
    logic        sel64;
    logic        issue_valid, issue_load, issue_store, mem_ack;
    logic [2:0]  func3;
    logic [63:0] addr, store_data, mem_rdata;
    logic [4:0]  rd_addr;

    int n_chk;
    int n_pass;

    mem_access_unit_if #(.XLEN(32)) if32 ();
    mem_access_unit_if #(.XLEN(64)) if64 ();

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(TMO)) dut32 (.CLK(CLK), .rst(rst), .bus(if32.master));
    mem_access_unit #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut64 (.CLK(CLK), .rst(rst), .bus(if64.master));

    assign if32.issue_valid = issue_valid & ~sel64;
    assign if32.issue_load  = issue_load;
    assign if32.issue_store = issue_store;
    assign if32.func3       = func3;
    assign if32.addr        = addr[31:0];
    assign if32.store_data  = store_data[31:0];
    assign if32.rd_addr     = rd_addr;
    assign if32.mem_rdata   = mem_rdata[31:0];
    assign if32.mem_ack     = mem_ack & ~sel64;
    assign if64.issue_valid = issue_valid & sel64;
    assign if64.issue_load  = issue_load;
    assign if64.issue_store = issue_store;
    assign if64.func3       = func3;
    assign if64.addr        = addr;
    assign if64.store_data  = store_data;
    assign if64.rd_addr     = rd_addr;
    assign if64.mem_rdata   = mem_rdata;
    assign if64.mem_ack     = mem_ack & sel64;

    logic        o_stall, o_req, o_we, o_lv, o_fault;
    logic [1:0]  o_cause;
    logic [63:0] o_addr, o_wdata, o_load;
    logic [7:0]  o_mask;
    logic [4:0]  o_rd;
    assign o_stall = sel64 ? if64.stall       : if32.stall;
    assign o_req   = sel64 ? if64.mem_req     : if32.mem_req;
    assign o_we    = sel64 ? if64.mem_we      : if32.mem_we;
    assign o_lv    = sel64 ? if64.load_valid  : if32.load_valid;
    assign o_fault = sel64 ? if64.fault       : if32.fault;
    assign o_cause = sel64 ? if64.fault_cause : if32.fault_cause;
    assign o_addr  = sel64 ? if64.mem_addr    : {32'h0, if32.mem_addr};
    assign o_wdata = sel64 ? if64.mem_wdata   : {32'h0, if32.mem_wdata};
    assign o_load  = sel64 ? if64.load_data   : {32'h0, if32.load_data};
    assign o_mask  = sel64 ? if64.mem_wmask   : {4'h0, if32.mem_wmask};
    assign o_rd    = sel64 ? if64.load_rd     : if32.load_rd;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: kind 0=accept, 1=misaligned, 2=illegal. Pure byte arithmetic.
    function automatic void model(input int xl, input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rdata,
                                  output int kind, output logic [63:0] e_addr, output logic [63:0] e_wdata,
                                  output logic [63:0] e_load, output logic [7:0] e_mask);
        logic [63:0] msk;
        logic [63:0] v;
        logic [63:0] sz;
        int nb, bw, lane;
        bit legal;
        msk = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb  = 1 << f3[1:0];
        bw  = xl / 8;
        if (ld && st)  legal = 1'b0;
        else if (ld)   legal = (f3 != 3'b111) && ((f3 != 3'b011 && f3 != 3'b110) || xl == 64);
        else if (st)   legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11 || xl == 64);
        else           legal = 1'b0;
        if (!legal)                  kind = 2;
        else if ((a % nb) != 64'd0)  kind = 1;
        else                         kind = 0;
        lane    = int'(a % bw);
        e_addr  = (a & msk) - 64'(lane);
        e_wdata = (sd << (8 * lane)) & msk;
        e_mask  = st ? 8'(((1 << nb) - 1) << lane) : 8'h00;
        v = (rdata & msk) >> (8 * lane);
        if (nb < 8) begin
            sz = (64'd1 << (8 * nb)) - 64'd1;
            v  = v & sz;
            if (!f3[2] && v[8 * nb - 1]) v = v | ~sz;
        end
        e_load = v & msk;
    endfunction

    // One full transaction; ack arrives on WAIT cycle ack_k (beyond TMO means none).
    task automatic run_txn(input bit s64, input bit ld, input bit st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rdata,
                           input logic [4:0] rd, input int ack_k);
        int kind;
        logic [63:0] e_addr, e_wdata, e_load;
        logic [7:0]  e_mask;
        model(s64 ? 64 : 32, ld, st, f3, a, sd, rdata, kind, e_addr, e_wdata, e_load, e_mask);
        sel64 = s64; issue_valid = 1'b1; issue_load = ld; issue_store = st;
        func3 = f3; addr = a; store_data = sd; rd_addr = rd; mem_ack = 1'b0;
        #1;
        check_eq("stall_issue", o_stall, (kind == 0));
        step();
        issue_valid = 1'b0; issue_load = 1'b0; issue_store = 1'b0;
        addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
        #1;
        if (kind != 0) begin
            check_eq("fault_pulse", o_fault, 1'b1);
            check_eq("fault_cause", o_cause, (kind == 1) ? 2'b01 : 2'b10);
            check_eq("req_on_fault", o_req, 1'b0);
            check_eq("stall_after_fault", o_stall, 1'b0);
            return;
        end
        for (int k = 1; k <= TMO; k++) begin
            check_eq("req_wait", o_req, 1'b1);
            check_eq("stall_wait", o_stall, 1'b1);
            check_eq("mem_addr", o_addr, e_addr);
            check_eq("mem_we", o_we, st);
            check_eq("mem_wmask", o_mask, e_mask);
            if (st) check_eq("mem_wdata", o_wdata, e_wdata);
            if (k == 1) begin
                check_eq("lv_not_in_wait", o_lv, 1'b0);
                check_eq("fault_not_in_wait", o_fault, 1'b0);
            end
            if (k == ack_k) begin
                mem_ack = 1'b1; mem_rdata = rdata;
                step();
                mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
                #1;
                check_eq("req_after_ack", o_req, 1'b0);
                check_eq("load_valid", o_lv, ld);
                check_eq("fault_after_ack", o_fault, 1'b0);
                if (ld) begin
                    check_eq("load_data", o_load, e_load);
                    check_eq("load_rd", o_rd, rd);
                end
                return;
            end
            mem_rdata = {$urandom, $urandom};
            step();
        end
        check_eq("req_after_tmo", o_req, 1'b0);
        check_eq("tmo_fault", o_fault, 1'b1);
        check_eq("tmo_cause", o_cause, 2'b11);
        check_eq("tmo_no_lv", o_lv, 1'b0);
        check_eq("tmo_stall", o_stall, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check_eq("late_ack_lv", o_lv, 1'b0);
        check_eq("late_ack_req", o_req, 1'b0);
        check_eq("tmo_pulse_end", o_fault, 1'b0);
    endtask

    // A cycle with no memory access (optionally a stray ack or a no-op issue).
    task automatic idle_cycle(input bit s64);
        sel64 = s64; issue_valid = 1'($urandom_range(0, 1)); issue_load = 1'b0; issue_store = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        check_eq("idle_stall", o_stall, 1'b0);
        step();
        issue_valid = 1'b0; mem_ack = 1'b0;
        #1;
        check_eq("idle_req", o_req, 1'b0);
        check_eq("idle_lv", o_lv, 1'b0);
        check_eq("idle_fault", o_fault, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        sel64 = 1'b0; rst = 1'b1; mem_ack = 1'b0; mem_rdata = 64'h0;
        issue_valid = 1'b1; issue_load = 1'b1; issue_store = 1'b0;
        func3 = 3'b010; addr = 64'h1000; store_data = 64'h0; rd_addr = 5'd3;
        step();
        #1;
        check_eq("stall_in_reset", o_stall, 1'b0);
        step();
        for (int s = 0; s < 2; s++) begin
            sel64 = 1'(s);
            #1;
            check_eq("rst_req", o_req, 1'b0);
            check_eq("rst_lv", o_lv, 1'b0);
            check_eq("rst_fault", o_fault, 1'b0);
            check_eq("rst_addr", o_addr, 64'h0);
            check_eq("rst_load", o_load, 64'h0);
        end
        rst = 1'b0; issue_valid = 1'b0; issue_load = 1'b0;
        step();

        // Directed scenarios.
        run_txn(1'b0, 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80FF_1234, 5'd7, 2);
        run_txn(1'b0, 1'b0, 1'b1, 3'b001, 64'h2002, 64'h1234_ABCD, 64'h0, 5'd0, 1);
        run_txn(1'b0, 1'b1, 1'b0, 3'b010, 64'h1002, 64'h0, 64'h0, 5'd1, 1);
        run_txn(1'b0, 1'b1, 1'b1, 3'b010, 64'h1004, 64'h0, 64'h0, 5'd1, 1);
        run_txn(1'b0, 1'b0, 1'b1, 3'b010, 64'h3000, 64'hCAFE_F00D, 64'h0, 5'd0, 99);
        run_txn(1'b0, 1'b1, 1'b0, 3'b010, 64'h3004, 64'h0, 64'h8765_4321, 5'd9, 3);
        run_txn(1'b0, 1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 64'h0, 5'd2, 1);
        run_txn(1'b1, 1'b1, 1'b0, 3'b110, 64'h0000_1234_5678_9AB4, 64'h0, 64'hF000_0000_0000_0000, 5'd11, 1);
        run_txn(1'b1, 1'b1, 1'b0, 3'b010, 64'h0000_1234_5678_9AB4, 64'h0, 64'hF000_0000_0000_0000, 5'd12, 2);
        run_txn(1'b1, 1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 5'd13, TMO);
        run_txn(1'b1, 1'b0, 1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 5'd0, 1);

        // Reset asserted in the second WAIT cycle, then a late ack.
        run_txn(1'b0, 1'b1, 1'b0, 3'b000, 64'h0, 64'h0, 64'h0, 5'd4, 1);
        sel64 = 1'b0; issue_valid = 1'b1; issue_load = 1'b1; func3 = 3'b000; addr = 64'h1003; rd_addr = 5'd5;
        step();
        issue_valid = 1'b0; issue_load = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check_eq("stall_rst_wait", o_stall, 1'b0);
        step();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h8080_8080;
        #1;
        check_eq("rstw_req", o_req, 1'b0);
        check_eq("rstw_lv", o_lv, 1'b0);
        check_eq("rstw_we", o_we, 1'b0);
        check_eq("rstw_addr", o_addr, 64'h0);
        check_eq("rstw_mask", o_mask, 8'h00);
        check_eq("rstw_wdata", o_wdata, 64'h0);
        check_eq("rstw_fault", o_fault, 1'b0);
        step();
        mem_ack = 1'b0;
        #1;
        check_eq("rstw_late_lv", o_lv, 1'b0);
        check_eq("rstw_late_req", o_req, 1'b0);

        // Randomized transactions, back-to-back with occasional idle gaps.
        for (int i = 0; i < 300; i++) begin
            bit s64, ld, st;
            int op;
            logic [2:0]  f3;
            logic [63:0] a;
            s64 = 1'($urandom_range(0, 1));
            op  = $urandom_range(0, 19);
            ld  = (op == 0) || (op >= 10);
            st  = (op <= 9);
            f3  = 3'($urandom_range(0, 7));
            a   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
            if ($urandom_range(0, 7) == 0) idle_cycle(s64);
            run_txn(s64, ld, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                    5'($urandom), $urandom_range(1, TMO + 2));
        end
        idle_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
